// File: rtl/load_store_ctrl.sv
// load_store_ctrl: MEM-stage load/store sequencer for a single-beat bus.
// Accepts one access from IDLE, holds it on the bus in BUS until ack or
// timeout, then reports the outcome for exactly one cycle in DONE.
module load_store_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        ld_valid,
  output logic        access_err,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
  // Outcome reported while in DONE; NONE covers completed stores.
  typedef enum logic [1:0] {EV_NONE, EV_LD, EV_AERR, EV_TERR} ev_t;

  state_t      state_q, state_d;
  ev_t         ev_q, ev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q, be_d;
  logic [31:0] wd_q, wd_d;
  logic        legal, accept;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Legality of the access presented in IDLE (alignment and funct3 decode).
  always_comb begin
    legal = 1'b0;
    case (funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~addr[0];
      3'b010:  legal = (addr[1:0] == 2'b00);
      3'b100:  legal = ~mem_we;
      3'b101:  legal = ~mem_we & ~addr[0];
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data; loads drive no enables.
  always_comb begin
    be_d = 4'b0000;
    wd_d = wdata;
    if (mem_we) begin
      case (funct3[1:0])
        2'b00: begin
          be_d = 4'b0001 << addr[1:0];
          wd_d = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_d = addr[1] ? 4'b1100 : 4'b0011;
          wd_d = {2{wdata[15:0]}};
        end
        default: begin
          be_d = 4'b1111;
          wd_d = wdata;
        end
      endcase
    end
  end

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  // Next-state, wait counter, outcome and result register update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_d    = EV_NONE;
    rdata_d = rdata_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_valid) begin
          if (legal) begin
            state_d = S_BUS;
            cnt_d   = 8'd0;
            accept  = 1'b1;
          end else begin
            state_d = S_DONE;
            ev_d    = EV_AERR;
            rdata_d = 32'd0;
          end
        end
      end
      S_BUS: begin
        // Ack on the last permitted cycle takes priority over the abort.
        if (bus_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            ev_d    = EV_LD;
            rdata_d = ld_ext;
          end
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          ev_d    = EV_TERR;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, result and latched access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ev_q    <= EV_NONE;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wd_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ev_q    <= ev_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q   <= mem_we;
        f3_q   <= funct3;
        addr_q <= addr;
        be_q   <= be_d;
        wd_q   <= wd_d;
      end
    end
  end

  assign stall       = ((state_q == S_IDLE) & mem_valid) | (state_q == S_BUS);
  assign bus_req     = (state_q == S_BUS);
  assign bus_we      = bus_req & we_q;
  assign bus_addr    = {addr_q[31:2], 2'b00};
  assign bus_be      = be_q;
  assign bus_wdata   = wd_q;
  assign rdata       = rdata_q;
  assign ld_valid    = (ev_q == EV_LD);
  assign access_err  = (ev_q == EV_AERR);
  assign timeout_err = (ev_q == EV_TERR);

endmodule

// File: tb/tb_load_store_ctrl.sv
// Randomized bench for load_store_ctrl with a transaction-level reference.
module tb_load_store_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, ld_valid, access_err, timeout_err;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_rdata = 32'd0;
  int last_stall, last_req;

  load_store_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .rdata(rdata), .ld_valid(ld_valid), .access_err(access_err),
    .timeout_err(timeout_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // ---- reference model: plain rules on the architectural access ----
  function automatic bit m_legal(input bit we, input int f3, input int a);
    int off = a % 4;
    if (f3 == 0) return 1;
    if (f3 == 1) return (off % 2) == 0;
    if (f3 == 2) return off == 0;
    if (f3 == 4) return !we;
    if (f3 == 5) return !we && (off % 2) == 0;
    return 0;
  endfunction

  function automatic logic [31:0] m_be(input int f3, input int a);
    int off = a % 4;
    if (f3 == 0) return 32'(1 << off);
    if (f3 == 1) return (off >= 2) ? 32'd12 : 32'd3;
    return 32'd15;
  endfunction

  function automatic logic [31:0] m_wd(input int f3, input logic [31:0] wd);
    if (f3 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int a, input logic [31:0] w);
    longint v;
    int off = a % 4;
    if (f3 == 0 || f3 == 4) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (f3 == 0 && v >= 128) v = v - 256;
    end else if (f3 == 1 || f3 == 5) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (f3 == 1 && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return 32'(v);
  endfunction

  // Run one access; slave acks after `delay` BUS cycles (>= TO means never).
  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int delay, input logic [31:0] word);
    bit ok, done;
    int n_stall, n_req, exp_req;
    bit e_ld, e_ae, e_te;
    ok = m_legal(we, int'(f3), int'(a[7:0]));
    exp_req = !ok ? 0 : (delay < TO ? delay + 1 : TO);
    e_ae = !ok;
    e_te = ok && delay >= TO;
    e_ld = ok && !we && delay < TO;
    if (e_ae || e_te) exp_rdata = 32'd0;
    else if (e_ld) exp_rdata = m_load(int'(f3), int'(a[7:0]), word);
    mem_valid = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    bus_rdata = word;
    n_stall = 0; n_req = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall) n_stall++;
      if (ld_valid || access_err || timeout_err) begin
        done = 1;
        chk("ld_valid", 32'(ld_valid), 32'(e_ld));
        chk("access_err", 32'(access_err), 32'(e_ae));
        chk("timeout_err", 32'(timeout_err), 32'(e_te));
        chk("rdata", rdata, exp_rdata);
        mem_valid = 1'b0;
      end else if (bus_req) begin
        chk("bus_addr", bus_addr, a & 32'hFFFFFFFC);
        chk("bus_we", 32'(bus_we), 32'(we));
        chk("bus_be", 32'(bus_be), we ? m_be(int'(f3), int'(a[7:0])) : 32'd0);
        if (we) chk("bus_wdata", bus_wdata, m_wd(int'(f3), wd));
        bus_ack = (n_req == delay);
        n_req++;
      end else if (c > 0 && !stall) begin
        // DONE for a store: no pulse, result register untouched.
        done = 1;
        chk("store_no_pulse", 32'(ld_valid | access_err | timeout_err), 32'd0);
        chk("store_rdata", rdata, exp_rdata);
        mem_valid = 1'b0;
      end else begin
        bus_ack = 1'($urandom_range(0, 1));  // must be ignored outside BUS
      end
      if (!done) @(negedge clk);
    end
    if (!done) chk("txn_budget", 32'd0, 32'd1);
    chk("req_cycles", 32'(n_req), 32'(exp_req));
    chk("stall_cycles", 32'(n_stall), 32'(1 + exp_req));
    last_stall = n_stall; last_req = n_req;
    bus_ack = 1'b0;
    @(negedge clk); #1;
    chk("pulse_clear", {29'd0, ld_valid, access_err, timeout_err}, 32'd0);
    chk("idle_req", 32'(bus_req), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    #7;
    chk("rst_outs", {26'd0, stall, bus_req, bus_we, ld_valid, access_err, timeout_err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus", bus_addr | bus_wdata | 32'(bus_be), 32'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);

    // Directed cases from the block's intended behaviour.
    do_txn(0, 3'b000, 32'h103, 0, 0, 32'h80123456);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_stall2", 32'(last_stall), 32'd2);
    do_txn(0, 3'b101, 32'h22, 0, 1, 32'hBEEF0001);
    chk("lhu_rdata", rdata, 32'h0000BEEF);
    do_txn(0, 3'b001, 32'h22, 0, 2, 32'hBEEF0001);
    chk("lh_rdata", rdata, 32'hFFFFBEEF);
    do_txn(1, 3'b000, 32'h41, 32'hAB, 0, 0);
    do_txn(1, 3'b001, 32'h42, 32'h1234, 1, 0);
    do_txn(0, 3'b010, 32'h06, 0, 0, 32'h55);
    chk("lw_mis_rdata", rdata, 32'd0);
    do_txn(0, 3'b000, 32'h10, 0, 0, 32'h7F);
    do_txn(0, 3'b011, 32'h10, 0, 0, 0);
    chk("f3_011_req", 32'(last_req), 32'd0);
    do_txn(0, 3'b010, 32'h80, 0, TO + 3, 32'h1111);
    chk("to_req4", 32'(last_req), 32'd4);
    do_txn(0, 3'b010, 32'h80, 0, TO - 1, 32'hCAFEF00D);
    chk("late_ack", rdata, 32'hCAFEF00D);

    // Reset while the bus is held.
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h40; bus_ack = 1'b0;
    @(negedge clk); mem_valid = 1'b0; #1;
    chk("pre_rst_req", 32'(bus_req), 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("rst_req_drop", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rdata2", rdata, 32'd0);
    exp_rdata = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus_ack = (c == 2);
      @(negedge clk); #1;
      chk("post_rst_quiet", {28'd0, bus_req, ld_valid, access_err, timeout_err}, 32'd0);
    end
    bus_ack = 1'b0;
    @(negedge clk);

    // Randomized accesses.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3));
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
             $urandom_range(0, TO + 1), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, max bus-wait cycles before abort (range 2..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_valid  input  1  MEM stage holds a load/store.
REQ-005 mem_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  width code: lb 000, lh 001, lw 010, lbu 100, lhu 101; stores sb 000, sh 001, sw 010.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, LSB-aligned.
REQ-009 stall  output  1  freeze pipeline.
REQ-010 rdata  output  32  extended load result, registered.
REQ-011 ld_valid  output  1  one-cycle pulse, rdata valid.
REQ-012 access_err  output  1  one-cycle pulse: misaligned or unsupported funct3.
REQ-013 timeout_err  output  1  one-cycle pulse: bus abort.
REQ-014 bus_req, bus_we  output  1 each  bus request / write.
REQ-015 bus_addr  output  32  {addr[31:2],2'b00}.
REQ-016 bus_be  output  4  byte enables (0000 for loads).
REQ-017 bus_wdata  output  32  lane-replicated store data.
REQ-018 bus_ack  input  1  slave completion, single cycle.
REQ-019 bus_rdata  input  32  read word, valid with bus_ack.

Function
REQ-020 FSM states IDLE, BUS, DONE; stall = (IDLE & mem_valid) | BUS, combinational; stall low in DONE.
REQ-021 IDLE & mem_valid & legal: latch mem_we/funct3/addr/wdata, go BUS, clear wait counter.
REQ-022 IDLE & mem_valid & illegal: go DONE with access_err=1, no bus_req, rdata=0.
REQ-023 Illegal = lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 100/101.
REQ-024 bus_req high exactly in BUS; bus_addr/bus_we/bus_be/bus_wdata stable from latched values throughout BUS.
REQ-025 bus_ack sampled only in BUS; ignored in IDLE/DONE.
REQ-026 BUS & bus_ack: go DONE; for loads register extracted rdata, ld_valid=1 in DONE.
REQ-027 Extraction: lane=addr[1:0]; lb/lbu byte bus_rdata[8*lane+:8] sign/zero-extended; lh/lhu half bus_rdata[16*addr[1]+:16] sign/zero-extended; lw full word.
REQ-028 Store enables: sb 4'b0001<<lane, wdata[7:0] x4; sh addr[1]?1100:0011, wdata[15:0] x2; sw 1111, wdata.
REQ-029 Wait counter increments each BUS cycle without ack; at count TIMEOUT-1 with no ack: go DONE, timeout_err=1, rdata=0, ld_valid=0.
REQ-030 Ack on the final permitted cycle wins over timeout.
REQ-031 DONE always returns to IDLE next cycle; ld_valid/access_err/timeout_err high only in DONE, mutually exclusive.
REQ-032 Latency: ack in first BUS cycle -> DONE 2 cycles after acceptance; stall high exactly 2 cycles.
REQ-033 mem_valid in DONE is not accepted until IDLE (back-to-back gap of one cycle).
REQ-034 rdata holds last value except updated on successful load or error (0).

Reset
REQ-035 rst_n low: state IDLE, counter 0, rdata 0, bus_req/ld_valid/access_err/timeout_err 0, bus_addr/bus_be/bus_wdata 0, immediately (asynchronous).
REQ-036 Reset in BUS drops bus_req at once; in-flight access abandoned, no completion pulse after release.

Verification
REQ-037 lb addr 0x103, bus_rdata 0x80_12_34_56 ack first BUS cycle -> bus_addr 0x100, rdata 0xFFFFFF80, ld_valid pulse, stall 2 cycles.
REQ-038 lhu addr 0x22, bus_rdata 0xBEEF0001 -> rdata 0x0000BEEF; lh same -> 0xFFFFBEEF.
REQ-039 sb addr 0x41 wdata 0xAB -> bus_be 0010, bus_wdata 0xABABABAB, bus_we 1; sh addr 0x42 -> be 1100.
REQ-040 lw addr 0x06 -> no bus_req, access_err pulse, rdata 0; funct3 011 same response.
REQ-041 Load with ack withheld, TIMEOUT=4 -> bus_req 4 cycles, timeout_err pulse, rdata 0; ack on 4th cycle -> ld_valid instead.
REQ-042 rst_n low during BUS with ack 3 cycles later -> bus_req 0 at once, no pulses, FSM IDLE.
